pending_encoder4to2: RTL

PENDING_ENCODER4TO2 -- requirements
Module: pending_encoder4to2

---
 rtl/pending_encoder4to2.sv | 105 ++++++++++
 1 files changed

// File: rtl/pending_encoder4to2.sv
// Pending-request priority encoder with a ready/valid output handshake.
// Requests on i1..i4 are captured into a sticky pending register. The
// highest-priority pending line is presented as a 2-bit code that stays
// stable until the consumer accepts it. A repeated request on a line that
// is already pending raises a sticky overrun flag.
module pending_encoder4to2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       rdy,
  output logic       y1,
  output logic       y2,
  output logic       vld,
  output logic       ovr,
  output logic [2:0] cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] code_q, code_d;
  logic       ovr_q, ovr_d;
  logic [2:0] cnt_q, cnt_d;

  logic [3:0] req;
  logic       accept;
  logic [3:0] acc_mask;
  logic [3:0] kept;

  // Code of the highest set bit; callers only use it on a non-zero vector.
  function automatic logic [1:0] top_code(input logic [3:0] v);
    logic [1:0] c;
    c = 2'd0;
    if (v[3])      c = 2'd3;
    else if (v[2]) c = 2'd2;
    else if (v[1]) c = 2'd1;
    return c;
  endfunction

  // Number of set bits in the pending vector.
  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Next-state logic: merge new requests, retire the accepted one, pick the next code.
  always_comb begin
    req      = {i4, i3, i2, i1};
    accept   = (state_q == HOLD) && rdy;
    acc_mask = accept ? (4'b0001 << code_q) : 4'b0000;
    kept     = pend_q & ~acc_mask;
    pend_d   = kept | req;
    ovr_d    = ovr_q | (|(req & kept));
    cnt_d    = pop4(pend_d);
    state_d  = state_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (pend_q != 4'b0000) begin
          code_d  = top_code(pend_q);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          if (pend_d != 4'b0000) begin
            code_d  = top_code(pend_d);
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset that clears everything, including the code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      code_q  <= 2'b00;
      ovr_q   <= 1'b0;
      cnt_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y1  = code_q[1];
  assign y2  = code_q[0];
  assign vld = (state_q == HOLD);
  assign ovr = ovr_q;
  assign cnt = cnt_q;

endmodule
